// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode encodings,
// status bit positions and the handshake state type.
package alu_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_EQ   = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_NE   = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_LT   = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] ALU_GE   = ALUOP_W'(13);
  localparam logic [ALUOP_W-1:0] ALU_LTU  = ALUOP_W'(14);
  localparam logic [ALUOP_W-1:0] ALU_GEU  = ALUOP_W'(15);

  localparam int ST_ZERO  = 0;
  localparam int ST_NEG   = 1;
  localparam int ST_CARRY = 2;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } aluState_e;

endpackage

// File: rtl/alu_shift.sv
// Combinational barrel shifter for the ALU's logical and arithmetic shifts.
// Opcodes other than the three shifts produce zero.
module alu_shift
  import alu_pkg::*;
#(
  parameter int REG_SZ = 32
) (
  input  logic [REG_SZ-1:0]         a_i,
  input  logic [$clog2(REG_SZ)-1:0] shamt_i,
  input  logic [ALUOP_W-1:0]        op_i,
  output logic [REG_SZ-1:0]         y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_SLL: y_o = a_i << shamt_i;
      ALU_SRL: y_o = a_i >> shamt_i;
      ALU_SRA: y_o = $signed(a_i) >>> shamt_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Execute-stage integer ALU with a run/ack handshake; operands are sampled
// on the accepting edge and the registered result is held until the next op.
module alu_core
  import alu_pkg::*;
#(
  parameter int REG_SZ = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_run,
  input  logic [REG_SZ-1:0]  A,
  input  logic [REG_SZ-1:0]  B,
  input  logic               c,
  input  logic [ALUOP_W-1:0] op,
  output logic [REG_SZ-1:0]  Y,
  output logic [2:0]         st,
  output logic               alu_ack
);

  localparam int SH_W = $clog2(REG_SZ);

  aluState_e         state_q, state_d;
  logic [REG_SZ-1:0] y_q, y_d;
  logic [2:0]        st_q, st_d;

  logic [REG_SZ:0]   addSum, subDiff, cExt;
  logic [REG_SZ-1:0] shiftRes, resNext;
  logic [2:0]        stNext;
  logic              carryNext, cmpFlag, isCmp;
  logic              signedLt, unsignedLt, equal;

  alu_shift #(
    .REG_SZ(REG_SZ)
  ) uShift (
    .a_i    (A),
    .shamt_i(B[SH_W-1:0]),
    .op_i   (op),
    .y_o    (shiftRes)
  );

  // The extra top bit of the widened add/sub is the carry-out or the borrow.
  always_comb begin
    cExt       = {{REG_SZ{1'b0}}, c};
    addSum     = {1'b0, A} + {1'b0, B} + cExt;
    subDiff    = {1'b0, A} - {1'b0, B} - cExt;
    signedLt   = $signed(A) < $signed(B);
    unsignedLt = A < B;
    equal      = A == B;
  end

  always_comb begin
    resNext   = '0;
    carryNext = 1'b0;
    cmpFlag   = 1'b0;
    isCmp     = 1'b0;
    case (op)
      ALU_ADD: begin
        resNext   = addSum[REG_SZ-1:0];
        carryNext = addSum[REG_SZ];
      end
      ALU_SUB: begin
        resNext   = subDiff[REG_SZ-1:0];
        carryNext = subDiff[REG_SZ];
      end
      ALU_SLL, ALU_SRL, ALU_SRA: resNext = shiftRes;
      ALU_AND: resNext = A & B;
      ALU_OR:  resNext = A | B;
      ALU_XOR: resNext = A ^ B;
      ALU_SLT, ALU_LT: begin isCmp = 1'b1; cmpFlag = signedLt;   end
      ALU_SLTU, ALU_LTU: begin isCmp = 1'b1; cmpFlag = unsignedLt; end
      ALU_EQ:  begin isCmp = 1'b1; cmpFlag = equal;       end
      ALU_NE:  begin isCmp = 1'b1; cmpFlag = !equal;      end
      ALU_GE:  begin isCmp = 1'b1; cmpFlag = !signedLt;   end
      ALU_GEU: begin isCmp = 1'b1; cmpFlag = !unsignedLt; end
      default: resNext = '0;
    endcase
    if (isCmp) begin
      resNext = {{(REG_SZ-1){1'b0}}, cmpFlag};
    end
    stNext           = '0;
    stNext[ST_ZERO]  = (resNext == '0);
    stNext[ST_NEG]   = resNext[REG_SZ-1];
    stNext[ST_CARRY] = carryNext;
  end

  // DONE lasts exactly one cycle and ignores run, so ops issue at most every other cycle.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    st_d    = st_q;
    case (state_q)
      IDLE: begin
        if (alu_run) begin
          state_d = DONE;
          y_d     = resNext;
          st_d    = stNext;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      st_q    <= st_d;
    end
  end

  assign Y       = y_q;
  assign st      = st_q;
  assign alu_ack = (state_q == DONE);

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core: handshake, arithmetic/status
// vectors, compares, shifts, back-to-back issue and reset abort.
module tb_alu_core;
  import alu_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               alu_run;
  logic [31:0]        A, B;
  logic               c;
  logic [ALUOP_W-1:0] op;
  logic [31:0]        Y;
  logic [2:0]         st;
  logic               alu_ack;

  int checks = 0;
  int errors = 0;

  alu_core #(.REG_SZ(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .alu_run(alu_run),
    .A      (A),
    .B      (B),
    .c      (c),
    .op     (op),
    .Y      (Y),
    .st     (st),
    .alu_ack(alu_ack)
  );

  always #5 clk = ~clk;

  // Issue one op with a single-cycle run pulse, scramble the operands right
  // after the start edge, and require exactly one ack within the window.
  task automatic applyStimulus(input logic [ALUOP_W-1:0] opIn, input logic [31:0] aIn,
                               input logic [31:0] bIn, input logic cIn, input string tag);
    int ackCount;
    ackCount = 0;
    op = opIn; A = aIn; B = bIn; c = cIn; alu_run = 1'b1;
    @(negedge clk);
    alu_run = 1'b0;
    A = ~aIn; B = ~bIn; c = ~cIn; op = ~opIn;
    if (alu_ack) ackCount++;
    repeat (3) begin
      @(negedge clk);
      if (alu_ack) ackCount++;
    end
    checks++;
    assert (ackCount === 1) else begin
      errors++;
      $error("[TB] FAIL %s ack pulses got %0d want 1", tag, ackCount);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expY, input logic [2:0] expSt);
    checks++;
    assert (Y === expY) else begin
      errors++;
      $error("[TB] FAIL %s Y got %h want %h", tag, Y, expY);
    end
    checks++;
    assert (st === expSt) else begin
      errors++;
      $error("[TB] FAIL %s st got %b want %b", tag, st, expSt);
    end
  endtask

  initial begin
    int firstIdx, secondIdx, ackCount;
    logic [31:0] y2;
    logic [2:0]  st2;

    rst = 1'b1; alu_run = 1'b0; A = '0; B = '0; c = 1'b0; op = ALU_ADD;
    repeat (3) @(negedge clk);
    checkOutput("reset", 32'h0, 3'b000);
    checks++;
    assert (alu_ack === 1'b0) else begin
      errors++;
      $error("[TB] FAIL reset_ack got %b want 0", alu_ack);
    end
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(ALU_ADD, 32'd5, 32'd7, 1'b0, "add_small");
    checkOutput("add_small", 32'd12, 3'b000);
    applyStimulus(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, "add_wrap");
    checkOutput("add_wrap", 32'h0, 3'b101);
    applyStimulus(ALU_ADD, 32'd10, 32'd20, 1'b1, "add_cin");
    checkOutput("add_cin", 32'd31, 3'b000);
    applyStimulus(ALU_SUB, 32'd3, 32'd5, 1'b0, "sub_neg");
    checkOutput("sub_neg", 32'hFFFF_FFFE, 3'b110);
    applyStimulus(ALU_SUB, 32'd5, 32'd5, 1'b1, "sub_bin");
    checkOutput("sub_bin", 32'hFFFF_FFFF, 3'b110);
    applyStimulus(ALU_SUB, 32'd9, 32'd4, 1'b0, "sub_pos");
    checkOutput("sub_pos", 32'd5, 3'b000);

    applyStimulus(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, "and");
    checkOutput("and", 32'h0000_00F0, 3'b000);
    applyStimulus(ALU_OR, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, "or");
    checkOutput("or", 32'h0000_FFF0, 3'b000);
    applyStimulus(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, "xor");
    checkOutput("xor", 32'h0000_FF00, 3'b000);

    applyStimulus(ALU_LT, 32'hFFFF_FFFF, 32'd1, 1'b0, "lt");
    checkOutput("lt", 32'd1, 3'b000);
    applyStimulus(ALU_LTU, 32'hFFFF_FFFF, 32'd1, 1'b0, "ltu");
    checkOutput("ltu", 32'd0, 3'b001);
    applyStimulus(ALU_EQ, 32'h1234, 32'h1234, 1'b0, "eq");
    checkOutput("eq", 32'd1, 3'b000);
    applyStimulus(ALU_GE, 32'd7, 32'd7, 1'b0, "ge");
    checkOutput("ge", 32'd1, 3'b000);
    applyStimulus(ALU_SLT, 32'hFFFF_FFFB, 32'd3, 1'b0, "slt");
    checkOutput("slt", 32'd1, 3'b000);
    applyStimulus(ALU_SLTU, 32'hFFFF_FFFB, 32'd3, 1'b0, "sltu");
    checkOutput("sltu", 32'd0, 3'b001);
    applyStimulus(ALU_NE, 32'd1, 32'd2, 1'b0, "ne");
    checkOutput("ne", 32'd1, 3'b000);
    applyStimulus(ALU_GEU, 32'd1, 32'd2, 1'b0, "geu");
    checkOutput("geu", 32'd0, 3'b001);

    applyStimulus(ALU_SRA, 32'h8000_0000, 32'd4, 1'b0, "sra");
    checkOutput("sra", 32'hF800_0000, 3'b010);
    applyStimulus(ALU_SRL, 32'h8000_0000, 32'd4, 1'b0, "srl");
    checkOutput("srl", 32'h0800_0000, 3'b000);
    applyStimulus(ALU_SLL, 32'd1, 32'd36, 1'b1, "sll");
    checkOutput("sll", 32'd16, 3'b000);

    // Back-to-back: run stays high, operands swap to an ADD during the first ack.
    firstIdx = -1; secondIdx = -1; y2 = 'x; st2 = 'x;
    op = ALU_EQ; A = 32'd5; B = 32'd5; c = 1'b0; alu_run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (alu_ack) begin
        if (firstIdx < 0) begin
          firstIdx = i;
          checks++;
          assert (Y[0] === 1'b1) else begin
            errors++;
            $error("[TB] FAIL b2b_cmp Y[0] got %b want 1", Y[0]);
          end
          op = ALU_ADD; A = 32'h100; B = 32'h23; c = 1'b0;
        end else if (secondIdx < 0) begin
          secondIdx = i;
          y2 = Y; st2 = st;
          alu_run = 1'b0;
        end
      end
    end
    alu_run = 1'b0;
    checks++;
    assert ((secondIdx - firstIdx) === 2) else begin
      errors++;
      $error("[TB] FAIL b2b_gap acks %0d cycles apart want 2", secondIdx - firstIdx);
    end
    checks++;
    assert (y2 === 32'h123) else begin
      errors++;
      $error("[TB] FAIL b2b_sum Y got %h want %h", y2, 32'h123);
    end
    checks++;
    assert (st2 === 3'b000) else begin
      errors++;
      $error("[TB] FAIL b2b_st st got %b want 000", st2);
    end

    // Reset coinciding with a start must abort it: no ack, outputs cleared.
    ackCount = 0;
    op = ALU_ADD; A = 32'd1; B = 32'd1; c = 1'b0; alu_run = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; alu_run = 1'b0;
    if (alu_ack) ackCount++;
    repeat (3) begin
      @(negedge clk);
      if (alu_ack) ackCount++;
    end
    checks++;
    assert (ackCount === 0) else begin
      errors++;
      $error("[TB] FAIL rst_abort ack pulses got %0d want 0", ackCount);
    end
    checkOutput("rst_abort", 32'h0, 3'b000);

    applyStimulus(ALU_ADD, 32'd2, 32'd3, 1'b0, "post_rst");
    checkOutput("post_rst", 32'd5, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
